// File: rtl/wb_copy_master.sv
// wb_copy_master: copies LEN 32-bit words from src_addr to dst_addr over a
// Wishbone B4 pipelined master port, one outstanding request at a time.
// Each word is a read (RD_REQ/RD_WAIT) followed by a write (WR_REQ/WR_WAIT).
// All bus and status outputs are registered and derived from the next state,
// so they always line up with the state register.
module wb_copy_master #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_adr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_stall_i,
  input  logic             wb_err_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // A zero TIMEOUT disables the abort entirely.
  localparam bit          TMO_EN   = (TIMEOUT > 0);
  localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t             state_r, state_s;
  logic [31:0]        src_r, src_s;
  logic [31:0]        dst_r, dst_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [31:0]        data_r, data_s;
  logic [31:0]        tmo_r, tmo_s;
  logic               armed_r;
  logic               tmo_hit_s;
  logic               error_s;
  logic [LEN_W-1:0]   words_s;
  logic               cyc_s, stb_s, we_s, busy_s, done_s;
  logic [31:0]        adr_s, dat_s;
  logic [3:0]         sel_s;

  // True for the states that own the bus (cyc held high).
  function automatic logic is_active(input state_t st);
    return (st == RD_REQ) || (st == RD_WAIT) || (st == WR_REQ) || (st == WR_WAIT);
  endfunction

  assign tmo_hit_s = TMO_EN && (tmo_r == TMO_LAST);

  // State register; armed_r holds the FSM still for one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_s;
      armed_r <= 1'b1;
    end
  end

  // Next-state, datapath updates and next values of all registered outputs.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    len_s   = len_r;
    data_s  = data_r;
    words_s = words_done;
    error_s = error;
    if (armed_r) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            words_s = '0;
            error_s = 1'b0;
            if (len != '0) begin
              src_s   = {src_addr[31:2], 2'b00};
              dst_s   = {dst_addr[31:2], 2'b00};
              len_s   = len;
              state_s = RD_REQ;
            end else begin
              state_s = FINISH;
            end
          end else begin
            state_s = IDLE;
          end
        end
        RD_REQ: begin
          if (!wb_stall_i) begin
            state_s = RD_WAIT;
          end else if (tmo_hit_s) begin
            state_s = FINISH;
            error_s = 1'b1;
          end else begin
            state_s = RD_REQ;
          end
        end
        RD_WAIT: begin
          // err wins over a simultaneous ack
          if (wb_err_i || (!wb_ack_i && tmo_hit_s)) begin
            state_s = FINISH;
            error_s = 1'b1;
          end else if (wb_ack_i) begin
            data_s  = wb_dat_i;
            state_s = WR_REQ;
          end else begin
            state_s = RD_WAIT;
          end
        end
        WR_REQ: begin
          if (!wb_stall_i) begin
            state_s = WR_WAIT;
          end else if (tmo_hit_s) begin
            state_s = FINISH;
            error_s = 1'b1;
          end else begin
            state_s = WR_REQ;
          end
        end
        WR_WAIT: begin
          if (wb_err_i || (!wb_ack_i && tmo_hit_s)) begin
            state_s = FINISH;
            error_s = 1'b1;
          end else if (wb_ack_i) begin
            words_s = words_done + LEN_W'(1);
            src_s   = src_r + 32'd4;
            dst_s   = dst_r + 32'd4;
            state_s = ((words_done + LEN_W'(1)) == len_r) ? FINISH : RD_REQ;
          end else begin
            state_s = WR_WAIT;
          end
        end
        FINISH:  state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end

    // Outputs follow the state being entered.
    cyc_s  = is_active(state_s);
    stb_s  = (state_s == RD_REQ) || (state_s == WR_REQ);
    we_s   = (state_s == WR_REQ) || (state_s == WR_WAIT);
    sel_s  = stb_s ? 4'hF : 4'h0;
    busy_s = (state_s != IDLE) && (state_s != FINISH);
    done_s = (state_s == FINISH);
    if (state_s == RD_REQ) begin
      adr_s = src_s;
    end else if (state_s == WR_REQ) begin
      adr_s = dst_s;
    end else begin
      adr_s = wb_adr_o;
    end
    if (state_s == WR_REQ) begin
      dat_s = data_s;
    end else begin
      dat_s = wb_dat_o;
    end

    // Restart the timeout count on every state change.
    if ((state_s != state_r) || !is_active(state_s)) begin
      tmo_s = 32'd0;
    end else begin
      tmo_s = tmo_r + 32'd1;
    end
  end

  // Datapath and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r      <= 32'd0;
      dst_r      <= 32'd0;
      len_r      <= '0;
      data_r     <= 32'd0;
      tmo_r      <= 32'd0;
      words_done <= '0;
      error      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 32'd0;
      wb_sel_o   <= 4'h0;
      wb_dat_o   <= 32'd0;
    end else begin
      src_r      <= src_s;
      dst_r      <= dst_s;
      len_r      <= len_s;
      data_r     <= data_s;
      tmo_r      <= tmo_s;
      words_done <= words_s;
      error      <= error_s;
      busy       <= busy_s;
      done       <= done_s;
      wb_cyc_o   <= cyc_s;
      wb_stb_o   <= stb_s;
      wb_we_o    <= we_s;
      wb_adr_o   <= adr_s;
      wb_sel_o   <= sel_s;
      wb_dat_o   <= dat_s;
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench for wb_copy_master: a Wishbone RAM slave model pops
// expected bus requests from a scoreboard queue filled when each copy starts.
module tb_wb_copy_master;

  localparam int LEN_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy, done, error;
  logic [LEN_W-1:0] words_done;
  logic             wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]      wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]       wb_sel_o;
  logic             wb_ack_i, wb_stall_i, wb_err_i;

  wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .wb_err_i(wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_errors = 0;

  // slave configuration (written by the main sequence only)
  bit rand_mode   = 1'b0;
  bit never_ack   = 1'b0;
  int err_write_n = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave model: acts on the falling edge, drives stall/ack/err for the next rising edge.
  initial begin : slave
    bit   pend = 1'b0;
    bit   stalled_prev = 1'b0;
    bit   err_issued = 1'b0;
    int   dly = 0;
    int   stall_run = 0;
    int   write_cnt = 0;
    req_t cur, held, e;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (err_issued) begin
        check("cyc_drop_after_err", {63'd0, wb_cyc_o}, 64'd0);
        err_issued = 1'b0;
      end
      if (!wb_cyc_o) begin
        pend = 1'b0;
        write_cnt = 0;
      end
      if (wb_stb_o) begin
        check("one_outstanding", {63'd0, pend}, 64'd0);
        check("sel", {60'd0, wb_sel_o}, 64'hF);
      end
      if (pend && !never_ack) begin
        if (dly == 0) begin
          pend = 1'b0;
          if (cur.we) begin
            write_cnt++;
            if (write_cnt == err_write_n) begin
              wb_err_i = 1'b1;
              wb_ack_i = 1'($urandom_range(0, 1));
              err_issued = 1'b1;
            end else begin
              mem[cur.adr] = cur.dat;
              wb_ack_i = 1'b1;
            end
          end else begin
            wb_dat_i = mem.exists(cur.adr) ? mem[cur.adr] : 32'hDEAD_BEEF;
            wb_ack_i = 1'b1;
          end
        end else begin
          dly--;
        end
      end
      if (wb_stb_o) begin
        if (stalled_prev) begin
          check("stall_stable_adr", {32'd0, wb_adr_o}, {32'd0, held.adr});
          check("stall_stable_we",  {63'd0, wb_we_o},  {63'd0, held.we});
          check("stall_stable_dat", {32'd0, wb_dat_o}, {32'd0, held.dat});
        end
        if (rand_mode && stall_run < 3 && ($urandom_range(0, 1) == 1)) begin
          wb_stall_i   = 1'b1;
          stall_run++;
          held         = '{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o};
          stalled_prev = 1'b1;
        end else begin
          wb_stall_i   = 1'b0;
          stall_run    = 0;
          stalled_prev = 1'b0;
          cur  = '{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o};
          pend = 1'b1;
          dly  = rand_mode ? int'($urandom_range(0, 3)) : 0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("req_we",  {63'd0, cur.we},  {63'd0, e.we});
            check("req_adr", {32'd0, cur.adr}, {32'd0, e.adr});
            if (e.we) check("req_dat", {32'd0, cur.dat}, {32'd0, e.dat});
          end
        end
      end else begin
        wb_stall_i   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        stalled_prev = 1'b0;
      end
    end
  end

  // Preload n source words, clear destination, queue the expected bus requests.
  task automatic prepare(input logic [31:0] s, input logic [31:0] d, input int n,
                         output logic [31:0] exp_dat[$]);
    logic [31:0] a, w;
    exp_dat = {};
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      w = $urandom;
      mem[a] = w;
      mem[d + 32'(4 * i)] = 32'd0;
      exp_dat.push_back(w);
      exp_q.push_back('{we: 1'b0, adr: a, dat: 32'd0});
      exp_q.push_back('{we: 1'b1, adr: d + 32'(4 * i), dat: w});
    end
  endtask

  task automatic run_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                          input int n, input int exp_cyc, input int exp_words,
                          input bit exp_err, input int exp_left, input int mid_start);
    logic [31:0] exp_dat[$];
    int cnt;
    bit cyc_seen, cyc_gap;
    prepare(s, d, n, exp_dat);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 2;                        // the start cycle is cycle 1
    cyc_seen = wb_cyc_o;
    cyc_gap  = 1'b0;
    check({nm, "_busy_after_start"}, {63'd0, busy}, {63'd0, (n != 0)});
    while (!done && cnt < 400) begin
      start = (cnt == mid_start);
      if (cnt == mid_start) begin
        src_addr = 32'h0000_0F00; len = LEN_W'(1);
      end
      @(posedge clk); #1;
      cnt++;
      if (cyc_seen && !wb_cyc_o && !done) cyc_gap = 1'b1;
      if (wb_cyc_o) cyc_seen = 1'b1;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, {63'd0, done}, 64'd1);
    if (exp_cyc > 0) check({nm, "_done_cycle"}, 64'(cnt), 64'(exp_cyc));
    check({nm, "_error"}, {63'd0, error}, {63'd0, exp_err});
    check({nm, "_words_done"}, 64'(words_done), 64'(exp_words));
    check({nm, "_finish_idle_bus"}, {62'd0, busy, wb_cyc_o}, 64'd0);
    check({nm, "_cyc_used"}, {63'd0, cyc_seen}, {63'd0, (n != 0)});
    check({nm, "_cyc_continuous"}, {63'd0, cyc_gap}, 64'd0);
    check({nm, "_left_in_queue"}, 64'(exp_q.size()), 64'(exp_left));
    exp_q.delete();
    if (!exp_err) begin
      for (int i = 0; i < n; i++)
        check({nm, "_mem"}, {32'd0, mem[d + 32'(4 * i)]}, {32'd0, exp_dat[i]});
    end
    // start in the FINISH cycle must be ignored
    start = 1'b1; len = LEN_W'(2);
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    check({nm, "_start_in_finish_ignored"}, {62'd0, busy, wb_cyc_o}, 64'd0);
  endtask

  initial begin : main
    logic [31:0] dummy[$];
    bit seen;
    rst_n = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = '0;
    #1;
    check("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, busy, done, error, wb_sel_o, words_done},
          64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_copy("basic",   32'h100, 32'h200, 4, 18, 4, 1'b0, 0, -1);
    rand_mode = 1'b1;
    run_copy("random",  32'h100, 32'h200, 4, -1, 4, 1'b0, 0, 5);
    rand_mode = 1'b0;
    run_copy("len0",    32'h100, 32'h200, 0, 2, 0, 1'b0, 0, -1);
    err_write_n = 2;
    run_copy("werr",    32'h400, 32'h500, 3, 10, 1, 1'b1, 2, -1);
    err_write_n = 0;
    never_ack = 1'b1;
    run_copy("timeout", 32'h600, 32'h680, 2, 11, 0, 1'b1, 3, -1);
    never_ack = 1'b0;
    run_copy("wrap",    32'hFFFF_FFF8, 32'h700, 4, 18, 4, 1'b0, 0, -1);

    // reset in the middle of a copy
    prepare(32'hFFFF_FFF8, 32'h800, 4, dummy);
    @(negedge clk);
    src_addr = 32'hFFFF_FFF8; dst_addr = 32'h800; len = LEN_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, busy, done, error, wb_sel_o, words_done},
          64'd0);
    check("midrst_bus", {wb_adr_o, wb_dat_o}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; len = LEN_W'(2);
    @(posedge clk); #1;
    start = 1'b0;
    check("first_edge_after_reset_holds", {62'd0, busy, wb_cyc_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("no_done_after_reset", {63'd0, seen}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
